// File: rtl/sound_event_scheduler_if.sv
// Signal bundle between game logic, the sound event scheduler and the tone generator.
// The master side produces event pulses and frame ticks; the slave side produces the tone controls.
interface sound_event_scheduler_if;
  logic       startOfFrame;
  logic       winPulse;
  logic       losePulse;
  logic       collisionPulse;
  logic       enable_sound;
  logic [3:0] freq;
  logic       busy;

  modport master (
    output startOfFrame,
    output winPulse,
    output losePulse,
    output collisionPulse,
    input  enable_sound,
    input  freq,
    input  busy
  );

  modport slave (
    input  startOfFrame,
    input  winPulse,
    input  losePulse,
    input  collisionPulse,
    output enable_sound,
    output freq,
    output busy
  );
endinterface

// File: rtl/sound_event_scheduler.sv
// Latches win/lose/collision pulses, picks the highest-priority one and plays
// its note sequence on the tone generator, timing notes and gaps in video frames.
module sound_event_scheduler #(
  parameter int NOTE_FRAMES = 10,
  parameter int GAP_FRAMES  = 2
) (
  input  logic                    clk,
  input  logic                    resetN,
  sound_event_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Event codes are ordered so that a larger code means higher priority.
  localparam logic [1:0] EVT_NONE = 2'd0;
  localparam logic [1:0] EVT_COL  = 2'd1;
  localparam logic [1:0] EVT_LOSE = 2'd2;
  localparam logic [1:0] EVT_WIN  = 2'd3;

  localparam logic [4:0] NOTE_LAST = 5'(NOTE_FRAMES - 1);
  localparam logic [4:0] GAP_LAST  = 5'(GAP_FRAMES - 1);

  state_t     r_state;
  logic [1:0] r_cur_evt;
  logic [1:0] r_note_idx;
  logic [4:0] r_frame_cnt;
  logic [2:0] r_pend;
  logic       r_enable;
  logic [3:0] r_freq;

  state_t     w_state_next;
  logic [1:0] w_evt_next;
  logic [1:0] w_idx_next;
  logic [4:0] w_cnt_next;
  logic [2:0] w_pend_next;
  logic [2:0] w_grant_mask;
  logic [2:0] w_pulse;
  logic [1:0] w_top_evt;
  logic       w_top_valid;
  logic       w_preempt;
  logic       w_last_note;

  function automatic logic [3:0] note_freq(input logic [1:0] evt, input logic [1:0] idx);
    logic [3:0] f;
    f = 4'd0;
    case (evt)
      EVT_WIN: begin
        case (idx)
          2'd0:    f = 4'd5;
          2'd1:    f = 4'd7;
          2'd2:    f = 4'd9;
          default: f = 4'd0;
        endcase
      end
      EVT_LOSE: begin
        case (idx)
          2'd0:    f = 4'd5;
          2'd1:    f = 4'd3;
          2'd2:    f = 4'd1;
          default: f = 4'd0;
        endcase
      end
      EVT_COL:  f = (idx == 2'd0) ? 4'd5 : 4'd0;
      default:  f = 4'd0;
    endcase
    return f;
  endfunction

  // Bit order of the pending vector: [0]=collision, [1]=lose, [2]=win.
  assign w_pulse = {bus.winPulse, bus.losePulse, bus.collisionPulse};

  // A pulse on the granting edge re-arms the latch, so the event is queued again.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
      assign w_pend_next[gi] = (r_pend[gi] & ~w_grant_mask[gi]) | w_pulse[gi];
    end
  endgenerate

  always_comb begin
    w_top_evt = EVT_NONE;
    if (r_pend[2])      w_top_evt = EVT_WIN;
    else if (r_pend[1]) w_top_evt = EVT_LOSE;
    else if (r_pend[0]) w_top_evt = EVT_COL;
  end

  assign w_top_valid = |r_pend;
  assign w_preempt   = (r_state != ST_IDLE) && (w_top_evt > r_cur_evt);
  assign w_last_note = (r_cur_evt == EVT_COL) ? (r_note_idx == 2'd0) : (r_note_idx == 2'd2);

  always_comb begin
    w_state_next = r_state;
    w_evt_next   = r_cur_evt;
    w_idx_next   = r_note_idx;
    w_cnt_next   = r_frame_cnt;
    w_grant_mask = 3'b000;

    // A grant or preemption ignores any frame tick landing on the same edge.
    if ((r_state == ST_IDLE && w_top_valid) || w_preempt) begin
      w_state_next = ST_NOTE;
      w_evt_next   = w_top_evt;
      w_idx_next   = 2'd0;
      w_cnt_next   = 5'd0;
      case (w_top_evt)
        EVT_WIN:  w_grant_mask = 3'b100;
        EVT_LOSE: w_grant_mask = 3'b010;
        EVT_COL:  w_grant_mask = 3'b001;
        default:  w_grant_mask = 3'b000;
      endcase
    end else if (bus.startOfFrame) begin
      case (r_state)
        ST_NOTE: begin
          if (r_frame_cnt == NOTE_LAST) begin
            w_cnt_next = 5'd0;
            if (w_last_note) begin
              w_state_next = ST_IDLE;
            end else if (GAP_FRAMES == 0) begin
              w_idx_next = r_note_idx + 2'd1;
            end else begin
              w_state_next = ST_GAP;
            end
          end else begin
            w_cnt_next = r_frame_cnt + 5'd1;
          end
        end
        ST_GAP: begin
          if (r_frame_cnt == GAP_LAST) begin
            w_state_next = ST_NOTE;
            w_idx_next   = r_note_idx + 2'd1;
            w_cnt_next   = 5'd0;
          end else begin
            w_cnt_next = r_frame_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they track the state exactly.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_cur_evt   <= EVT_NONE;
      r_note_idx  <= 2'd0;
      r_frame_cnt <= 5'd0;
      r_pend      <= 3'b000;
      r_enable    <= 1'b0;
      r_freq      <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_cur_evt   <= w_evt_next;
      r_note_idx  <= w_idx_next;
      r_frame_cnt <= w_cnt_next;
      r_pend      <= w_pend_next;
      r_enable    <= (w_state_next == ST_NOTE);
      r_freq      <= (w_state_next == ST_NOTE) ? note_freq(w_evt_next, w_idx_next) : 4'd0;
    end
  end

  assign bus.enable_sound = r_enable;
  assign bus.freq         = r_freq;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler with NOTE_FRAMES=3, GAP_FRAMES=2;
// frame ticks are driven explicitly so every expected output is known per cycle.
module tb_sound_event_scheduler;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sound_event_scheduler_if sif ();

  sound_event_scheduler #(
    .NOTE_FRAMES (3),
    .GAP_FRAMES  (2)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (sif.slave)
  );

  // Drive the inputs for exactly one sampling edge, then observe 1 time unit later.
  task automatic cyc(input logic w, input logic l, input logic c, input logic s);
    sif.winPulse       = w;
    sif.losePulse      = l;
    sif.collisionPulse = c;
    sif.startOfFrame   = s;
    @(posedge clk);
    #1;
    sif.winPulse       = 1'b0;
    sif.losePulse      = 1'b0;
    sif.collisionPulse = 1'b0;
    sif.startOfFrame   = 1'b0;
  endtask

  // One video frame: three quiet cycles and a startOfFrame cycle.
  task automatic frame();
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Starts on the cycle right after a grant; checks {enable_sound, freq, busy}
  // through every note and gap until the edge that re-enters IDLE.
  task automatic play_seq(input string tag, input int n,
                          input logic [3:0] f0, input logic [3:0] f1, input logic [3:0] f2);
    logic [3:0] f [3];
    logic [5:0] exp;
    logic [5:0] got;
    f = '{f0, f1, f2};
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (k > 0) frame();
        exp = {1'b1, f[i], 1'b1};
        got = {sif.enable_sound, sif.freq, sif.busy};
        vectors++;
        if (got !== exp) begin
          $display("FAIL %s_note%0d_frame%0d: got en/freq/busy=%b/%0d/%b need %b/%0d/%b",
                   tag, i, k, got[5], got[4:1], got[0], exp[5], exp[4:1], exp[0]);
          miscompares++;
        end
      end
      frame();
      exp = (i == n - 1) ? 6'b0 : 6'b000001;
      got = {sif.enable_sound, sif.freq, sif.busy};
      vectors++;
      if (got !== exp) begin
        $display("FAIL %s_note%0d_end: got en/freq/busy=%b/%0d/%b need %b/%0d/%b",
                 tag, i, got[5], got[4:1], got[0], exp[5], exp[4:1], exp[0]);
        miscompares++;
      end
      $display("%s: note %0d freq %0d checked", tag, i, f[i]);
      if (i < n - 1) begin
        frame();
        exp = 6'b000001;
        got = {sif.enable_sound, sif.freq, sif.busy};
        vectors++;
        if (got !== exp) begin
          $display("FAIL %s_gap%0d: got en/freq/busy=%b/%0d/%b need 0/0/1",
                   tag, i, got[5], got[4:1], got[0]);
          miscompares++;
        end
        frame();
      end
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({sif.enable_sound, sif.freq, sif.busy} !== 6'b0) begin
      $display("FAIL reset_asserted: got %b need 000000", {sif.enable_sound, sif.freq, sif.busy});
      miscompares++;
    end
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      else            cyc(1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if ({sif.enable_sound, sif.freq, sif.busy} !== 6'b0) begin
        $display("FAIL reset_idle%0d: got %b need 000000", i, {sif.enable_sound, sif.freq, sif.busy});
        miscompares++;
      end
    end
    $display("reset: outputs idle after release");
  endtask

  task automatic test_collision();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if ({sif.enable_sound, sif.busy} !== 2'b00) begin
      $display("FAIL col_latch_cycle: got en/busy=%b need 00", {sif.enable_sound, sif.busy});
      miscompares++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_seq("col", 1, 4'd5, 4'd0, 4'd0);
  endtask

  task automatic test_win();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_seq("win", 3, 4'd5, 4'd7, 4'd9);
  endtask

  task automatic test_simultaneous();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_seq("sim_win", 3, 4'd5, 4'd7, 4'd9);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_seq("sim_lose", 3, 4'd5, 4'd3, 4'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_seq("sim_col", 1, 4'd5, 4'd0, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({sif.enable_sound, sif.freq, sif.busy} !== 6'b0) begin
      $display("FAIL sim_drained: got %b need 000000", {sif.enable_sound, sif.freq, sif.busy});
      miscompares++;
    end
  endtask

  task automatic test_preemption();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    frame();
    frame();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({sif.enable_sound, sif.freq, sif.busy} !== {1'b1, 4'd5, 1'b1}) begin
      $display("FAIL pre_col_playing: got %b need 1_0101_1", {sif.enable_sound, sif.freq, sif.busy});
      miscompares++;
    end
    // Frame tick on the preempting edge would end the collision note; the restart must win.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if ({sif.enable_sound, sif.freq, sif.busy} !== {1'b1, 4'd5, 1'b1}) begin
      $display("FAIL pre_restart: got %b need 1_0101_1", {sif.enable_sound, sif.freq, sif.busy});
      miscompares++;
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    play_seq("pre_lose", 3, 4'd5, 4'd3, 4'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_seq("pre_col", 1, 4'd5, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      frame();
      vectors++;
      if ({sif.enable_sound, sif.freq, sif.busy} !== 6'b0) begin
        $display("FAIL pre_no_resume%0d: got %b need 000000", i, {sif.enable_sound, sif.freq, sif.busy});
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    play_seq("b2b_win1", 3, 4'd5, 4'd7, 4'd9);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    play_seq("b2b_win2", 3, 4'd5, 4'd7, 4'd9);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({sif.enable_sound, sif.freq, sif.busy} !== 6'b0) begin
      $display("FAIL b2b_drained: got %b need 000000", {sif.enable_sound, sif.freq, sif.busy});
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    frame();
    vectors++;
    if ({sif.enable_sound, sif.freq, sif.busy} !== {1'b1, 4'd5, 1'b1}) begin
      $display("FAIL rst_mid_playing: got %b need 1_0101_1", {sif.enable_sound, sif.freq, sif.busy});
      miscompares++;
    end
    #2;
    resetN = 1'b0;
    #1;
    vectors++;
    if ({sif.enable_sound, sif.freq, sif.busy} !== 6'b0) begin
      $display("FAIL rst_mid_async: got %b need 000000", {sif.enable_sound, sif.freq, sif.busy});
      miscompares++;
    end
    #2;
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame();
      vectors++;
      if ({sif.enable_sound, sif.freq, sif.busy} !== 6'b0) begin
        $display("FAIL rst_mid_silent%0d: got %b need 000000", i, {sif.enable_sound, sif.freq, sif.busy});
        miscompares++;
      end
    end
    $display("reset_mid: silenced and pending collision dropped");
  endtask

  initial begin
    sif.winPulse       = 1'b0;
    sif.losePulse      = 1'b0;
    sif.collisionPulse = 1'b0;
    sif.startOfFrame   = 1'b0;
    test_reset();
    test_collision();
    test_win();
    test_simultaneous();
    test_preemption();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_event_scheduler.md
# sound_event_scheduler

Queues the game's sound-event pulses (win, lose, collision), arbitrates between them by fixed priority and plays each as a short multi-note sequence on the shared tone generator. Note and gap durations are timed in video frames. The block sits between the game-logic event pulses and the tone generator's `enable_sound`/`freq` inputs. It is the only driver of that generator.

## Interface
- `NOTE_FRAMES`, default 10: frames per note. Legal range 1..31.
- `GAP_FRAMES`, default 2: silent frames between notes of one sequence. Legal range 0..31.
- `clk`  in  1: system clock.
- `resetN`  in  1: asynchronous, active-low reset.
- `startOfFrame`  in  1: one-cycle pulse per video frame.
- `winPulse`  in  1: one-cycle win event.
- `losePulse`  in  1: one-cycle lose event.
- `collisionPulse`  in  1: one-cycle ball-collision event.
- `enable_sound`  out  1: tone generator enable. Registered.
- `freq`  out  4: tone index. Registered. Equals 0 whenever `enable_sound`=0.
- `busy`  out  1: high while a sequence is in progress (state ≠ IDLE).

One clock (`clk`). Reset is asynchronous and active-low (`resetN`).

## Operation
- **Pending latches:** `pend_win`, `pend_lose`, `pend_col`.
  - Each is set on the edge that samples its pulse.
  - Each is cleared on the edge that grants that event.
  - If a pulse and the grant of the same event land on the same edge, the set wins and the event is re-queued.
  - Repeated pulses coalesce into one pending bit.
- **Priority:** win > lose > collision.
- **Sequences:** notes are played in order; `cur_evt` holds the event being played.
  - win: 5, 7, 9
  - lose: 5, 3, 1
  - collision: 5 (single note)
- **State machine:** states IDLE, NOTE, GAP. Registers: `cur_evt` (2b), `note_idx` (2b), `frame_cnt` (5b).
  - **IDLE.** If any pending bit is set: grant the highest-priority pending event, clear its bit, set `note_idx`=0 and `frame_cnt`=0, go to NOTE. Otherwise stay.
  - **NOTE.** `enable_sound`=1, `freq`=note[`cur_evt`][`note_idx`].
    - On each `startOfFrame`, `frame_cnt` increments.
    - On the `startOfFrame` where `frame_cnt`==`NOTE_FRAMES`-1:
      - last note → IDLE;
      - otherwise, `GAP_FRAMES`=0 → NOTE with `note_idx`+1 and `frame_cnt`=0;
      - otherwise → GAP with `frame_cnt`=0.
  - **GAP.** `enable_sound`=0, `freq`=0. Counts `startOfFrame` the same way. On the `startOfFrame` where `frame_cnt`==`GAP_FRAMES`-1 → NOTE with `note_idx`+1 and `frame_cnt`=0.
- **Preemption (NOTE or GAP):**
  - If a pending event has strictly higher priority than `cur_evt`, the next edge restarts: load that event, clear its bit, `note_idx`=0, `frame_cnt`=0, state NOTE.
  - Preemption takes precedence over a frame-end transition on the same edge.
  - The preempted sequence is discarded, not resumed.
  - Equal- or lower-priority pulses stay pending and play after the current sequence.
- **End of a sequence:** there is always exactly one IDLE cycle (`enable_sound`=0) before the next grant.
- **Counter width:** `frame_cnt` never exceeds 30 and never wraps, because parameters are limited to ≤31.

## Timing
- **Reset:** asserting `resetN` low immediately clears all state.
  - State=IDLE; all pending bits=0; `cur_evt`, `note_idx`, `frame_cnt`=0.
  - `enable_sound`=0, `freq`=0, `busy`=0.
  - Reset mid-sequence silences the output at once; pending events are lost.
- **Latency:** a pulse sampled at edge E (block in IDLE) gives `enable_sound`=1 and the correct `freq` after edge E+1. Preemption latency is the same.
- **Note length:** the first frame of a note is partial, so a note lasts from (`NOTE_FRAMES`-1) full frames plus a fraction up to `NOTE_FRAMES` frames. Gaps are timed the same way.
- **`startOfFrame` coinciding with entry:** a `startOfFrame` on the same edge as the grant or preemption is not counted.
- **Simultaneous pulses:** all are latched on the same edge; the highest priority is granted next edge and the rest play in priority order afterwards.
- **`busy`:** registered with the state; high from the grant edge until the edge that enters IDLE.

## Test plan
- **Reset values:** reset, then release with no pulses → `enable_sound`=0, `freq`=0, `busy`=0 indefinitely.
- **Single collision:** `collisionPulse` at edge E, SOF every 20 cycles, `NOTE_FRAMES`=3 → `enable_sound`=1, `freq`=5 from E+1; low after the 3rd SOF; `busy` falls on the same edge.
- **Win sequence:** `winPulse`, `NOTE_FRAMES`=3, `GAP_FRAMES`=2 → `freq` sequence 5, 7, 9, each note 3 SOFs, 2-SOF silent gaps between notes, then IDLE.
- **Simultaneous pulses:** win, lose and collision on the same cycle → win sequence, 1 idle cycle, lose sequence (5, 3, 1), 1 idle cycle, collision (5).
- **Preemption:** `collisionPulse`, then `losePulse` two frames in → lose note 5 restarts within 1 cycle and the collision sequence is not resumed. A `collisionPulse` during the lose sequence plays after it.
- **Reset mid-operation:** `resetN` low in the middle of a win note with `pend_col` set → outputs drop to 0 asynchronously; after release, no sound is produced.
